// File: rtl/cordic_cos_unit.sv
// Single-precision cosine engine: float angle -> Q2.30 -> rotation-mode CORDIC -> float.
// FOLD_FACT micro-rotations are unrolled per enabled clock; all state holds while clk_en=0.
module cordic_cos_unit #(
    parameter int CORD_ITER = 16,
    parameter int FOLD_FACT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] x_ft,
    output logic        done,
    output logic [31:0] y_ft
);

    typedef enum logic [1:0] {IDLE, CONV, ITER, NORM} state_t;

    localparam logic signed [31:0] K_INIT    = 32'sh26DD3B6A;
    localparam logic signed [31:0] ONE_Q30   = 32'sh40000000;
    localparam logic        [5:0]  LAST_BASE = 6'(CORD_ITER - FOLD_FACT);
    localparam logic        [5:0]  FOLD_STEP = 6'(FOLD_FACT);

    state_t             state_reg, state_next;
    logic        [31:0] x_in_reg;
    logic signed [31:0] x_reg, y_reg, z_reg;
    logic        [5:0]  iter_reg;
    logic               done_reg;
    logic        [31:0] y_ft_reg;

    // atan(2^-i) in Q2.30, truncated
    function automatic logic signed [31:0] atan_rom(input logic [5:0] idx);
        case (idx)
            6'd0:    atan_rom = 32'sh3243F6A8;
            6'd1:    atan_rom = 32'sh1DAC6705;
            6'd2:    atan_rom = 32'sh0FADBAFC;
            6'd3:    atan_rom = 32'sh07F56EA6;
            6'd4:    atan_rom = 32'sh03FEAB76;
            6'd5:    atan_rom = 32'sh01FFD55B;
            6'd6:    atan_rom = 32'sh00FFFAAA;
            6'd7:    atan_rom = 32'sh007FFF55;
            6'd8:    atan_rom = 32'sh003FFFEA;
            6'd9:    atan_rom = 32'sh001FFFFD;
            6'd10:   atan_rom = 32'sh000FFFFF;
            6'd11:   atan_rom = 32'sh0007FFFF;
            6'd12:   atan_rom = 32'sh0003FFFF;
            6'd13:   atan_rom = 32'sh0001FFFF;
            6'd14:   atan_rom = 32'sh0000FFFF;
            6'd15:   atan_rom = 32'sh00007FFF;
            6'd16:   atan_rom = 32'sh00003FFF;
            6'd17:   atan_rom = 32'sh00001FFF;
            6'd18:   atan_rom = 32'sh00000FFF;
            6'd19:   atan_rom = 32'sh000007FF;
            6'd20:   atan_rom = 32'sh000003FF;
            6'd21:   atan_rom = 32'sh000001FF;
            6'd22:   atan_rom = 32'sh000000FF;
            6'd23:   atan_rom = 32'sh0000007F;
            6'd24:   atan_rom = 32'sh0000003F;
            6'd25:   atan_rom = 32'sh0000001F;
            6'd26:   atan_rom = 32'sh0000000F;
            6'd27:   atan_rom = 32'sh00000008;
            6'd28:   atan_rom = 32'sh00000004;
            6'd29:   atan_rom = 32'sh00000002;
            default: atan_rom = 32'sh00000000;
        endcase
    endfunction

    // Float -> signed Q2.30 angle, with underflow to zero and saturation to +/-1.0
    logic        [7:0]  in_exp;
    logic        [31:0] in_mant;
    logic signed [31:0] z_mag, z_angle, z0;

    assign in_exp  = x_in_reg[30:23];
    assign in_mant = {9'd1, x_in_reg[22:0]};

    always_comb begin
        z_mag = '0;
        if (in_exp <= 8'd96)
            z_mag = '0;
        else if (in_exp > 8'd127 || (in_exp == 8'd127 && x_in_reg[22:0] != 23'd0))
            z_mag = ONE_Q30;
        else if (in_exp >= 8'd120)
            z_mag = signed'(in_mant << (in_exp - 8'd120));
        else
            z_mag = signed'(in_mant >> (8'd120 - in_exp));
        z_angle = x_in_reg[31] ? -z_mag : z_mag;
        // cos is even: rotating by |angle| makes cos(-x) bit-identical to cos(x)
        z0 = (z_angle < 0) ? -z_angle : z_angle;
    end

    // Unrolled micro-rotations for one enabled clock
    logic signed [31:0] atan_step [FOLD_FACT];
    logic        [5:0]  shift_step [FOLD_FACT];

    generate
        for (genvar gi = 0; gi < FOLD_FACT; gi++) begin : g_fold
            assign shift_step[gi] = iter_reg + 6'(gi);
            assign atan_step[gi]  = atan_rom(shift_step[gi]);
        end
    endgenerate

    logic signed [31:0] x_rot, y_rot, z_rot;

    always_comb begin
        logic signed [31:0] x_prev;
        x_rot = x_reg;
        y_rot = y_reg;
        z_rot = z_reg;
        for (int k = 0; k < FOLD_FACT; k++) begin
            x_prev = x_rot;
            if (z_rot >= 0) begin
                x_rot = x_rot - (y_rot >>> shift_step[k]);
                y_rot = y_rot + (x_prev >>> shift_step[k]);
                z_rot = z_rot - atan_step[k];
            end else begin
                x_rot = x_rot + (y_rot >>> shift_step[k]);
                y_rot = y_rot - (x_prev >>> shift_step[k]);
                z_rot = z_rot + atan_step[k];
            end
        end
    end

    // Q2.30 -> float: leading-one detect, truncating 23-bit mantissa
    logic [4:0]  lead_pos;
    logic [31:0] norm_shift;
    logic [31:0] y_norm;

    always_comb begin
        lead_pos = '0;
        for (int k = 0; k < 30; k++) begin
            if (x_reg[k]) lead_pos = 5'(k);
        end
        norm_shift = 32'(x_reg) << (5'd31 - lead_pos);
        if (x_reg <= 0)
            y_norm = 32'h0;
        else if (x_reg >= ONE_Q30)
            y_norm = 32'h3F800000;
        else
            y_norm = {1'b0, 8'(lead_pos) + 8'd97, norm_shift[30:8]};
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CONV;
            CONV:    state_next = ITER;
            ITER:    if (iter_reg == LAST_BASE) state_next = NORM;
            NORM:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (reset) state_reg <= IDLE;
            else       state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (reset) begin
                x_in_reg <= '0;
                x_reg    <= '0;
                y_reg    <= '0;
                z_reg    <= '0;
                iter_reg <= '0;
                done_reg <= 1'b0;
                y_ft_reg <= '0;
            end else begin
                done_reg <= 1'b0;
                case (state_reg)
                    IDLE: if (start) x_in_reg <= x_ft;
                    CONV: begin
                        x_reg    <= K_INIT;
                        y_reg    <= '0;
                        z_reg    <= z0;
                        iter_reg <= '0;
                    end
                    ITER: begin
                        x_reg    <= x_rot;
                        y_reg    <= y_rot;
                        z_reg    <= z_rot;
                        iter_reg <= iter_reg + FOLD_STEP;
                    end
                    NORM: begin
                        y_ft_reg <= y_norm;
                        done_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign done = done_reg;
    assign y_ft = y_ft_reg;

endmodule

// File: tb/tb_cordic_cos_unit.sv
// Directed bench for cordic_cos_unit: reference cosines, symmetry, saturation, latency,
// clock-enable stalls and mid-operation reset.
module tb_cordic_cos_unit;

    logic        clk = 1'b0;
    logic        reset, clk_en, start;
    logic [31:0] x_ft;
    logic        done;
    logic [31:0] y_ft;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cordic_cos_unit #(.CORD_ITER(16), .FOLD_FACT(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .x_ft   (x_ft),
        .done   (done),
        .y_ft   (y_ft)
    );

    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        for (int i = 0; i < e; i++) v = v * 2.0;
        for (int i = 0; i > e; i--) v = v / 2.0;
        return b[31] ? -v : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bits(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_close(input string tag, input logic [31:0] obs, input real exp);
        real v;
        bit  ok;
        v  = f2r(obs);
        ok = (v - exp <= 1.0e-4) && (exp - v <= 1.0e-4);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%h (%f) expected=%f", tag, obs, v, exp);
        end
    endtask

    // One transaction: accept, wait for done (bounded), then check pulse shape and hold.
    task automatic run_op(input string tag, input logic [31:0] x, input bit toggle,
                          input int hold, output logic [31:0] res);
        int lat;
        int extra;
        bit got;
        clk_en = 1'b1;
        start  = 1'b1;
        x_ft   = x;
        step();
        x_ft = ~x;
        lat  = 0;
        got  = 1'b0;
        for (int cyc = 0; cyc < 100 && !got; cyc++) begin
            start  = (cyc < hold);
            clk_en = toggle ? (cyc % 2 == 1) : 1'b1;
            step();
            if (clk_en) lat++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        res   = y_ft;
        checks++;
        assert (got === 1'b1) else begin
            errors++;
            $error("FAIL %s_timeout observed=no_done expected=done", tag);
        end
        check_bits({tag, "_latency"}, 32'(lat), 32'd6);
        $display("op %s x=%h y=%h (%f) latency=%0d", tag, x, res, f2r(res), lat);
        if (toggle) begin
            clk_en = 1'b0;
            step();
            check_bits({tag, "_done_stretch"}, {31'd0, done}, 32'd1);
        end
        clk_en = 1'b1;
        step();
        check_bits({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        extra = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            step();
            if (done) extra++;
        end
        check_bits({tag, "_no_extra_done"}, 32'(extra), 32'd0);
        check_bits({tag, "_y_hold"}, y_ft, res);
    endtask

    initial begin
        logic [31:0] r_zero, r_one, r_neg_one, r_half, r_half_t, r_sat, r_q, r_neg_q;
        logic [31:0] r_nan, r_tiny, r_after;
        int          stray;

        reset = 1'b1; clk_en = 1'b1; start = 1'b0; x_ft = 32'h0;
        step();
        step();
        check_bits("reset_done", {31'd0, done}, 32'd0);
        check_bits("reset_y", y_ft, 32'h0);
        reset = 1'b0;
        step();

        run_op("cos0", 32'h00000000, 1'b0, 0, r_zero);
        check_close("cos0_val", r_zero, 1.0);

        run_op("cos1", 32'h3F800000, 1'b0, 0, r_one);
        check_close("cos1_val", r_one, 0.5403023);

        run_op("cosm1", 32'hBF800000, 1'b0, 0, r_neg_one);
        check_bits("cos_even", r_neg_one, r_one);

        run_op("cos05", 32'h3F000000, 1'b0, 0, r_half);
        check_close("cos05_val", r_half, 0.8775826);

        run_op("cos05_stall", 32'h3F000000, 1'b1, 0, r_half_t);
        check_bits("stall_same", r_half_t, r_half);

        run_op("cos3_hold", 32'h40400000, 1'b0, 3, r_sat);
        check_bits("sat_eq_one", r_sat, r_one);

        run_op("cosq", 32'h3E800000, 1'b0, 0, r_q);
        check_close("cos025_val", r_q, 0.9689124);

        run_op("cosm075", 32'hBF400000, 1'b0, 0, r_neg_q);
        check_close("cosm075_val", r_neg_q, 0.7316889);

        run_op("nan", 32'h7FC00000, 1'b0, 0, r_nan);
        check_bits("nan_sat", r_nan, r_one);

        run_op("tiny", 32'h2F800000, 1'b0, 0, r_tiny);
        check_close("tiny_val", r_tiny, 1.0);

        // reset is ignored while the clock enable is low
        clk_en = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0; clk_en = 1'b1;
        check_bits("reset_gated", y_ft, r_tiny);

        // abort mid-iteration, then a fresh request
        start = 1'b1; x_ft = 32'h3F800000;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_bits("abort_done", {31'd0, done}, 32'd0);
        check_bits("abort_y", y_ft, 32'h0);
        stray = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            step();
            if (done) stray++;
        end
        check_bits("abort_no_done", 32'(stray), 32'd0);
        $display("op abort y=%h stray_done=%0d", y_ft, stray);

        run_op("after_abort", 32'h3F000000, 1'b0, 0, r_after);
        check_bits("after_abort_val", r_after, r_half);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
